// File: rtl/interfpga_pkg.sv
// Shared framing helpers and FSM encoding for the inter-FPGA lane link.
// The matching receiver imports this package so both ends agree on framing.
package interfpga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

   // Lane beats per word.
   function automatic int unsigned beats(input int unsigned data_w, input int unsigned lane_w);
      return data_w / lane_w;
   endfunction

   // Cycles a frame keeps ctrl high.
   function automatic int unsigned frame(input int unsigned data_w, input int unsigned lane_w,
                                         input int unsigned hold);
      return beats(data_w, lane_w) * hold;
   endfunction

endpackage

// File: rtl/interfpga_send_fifo_if.sv
// Producer-side handshake plus lane/status outputs of the inter-FPGA sender.
interface interfpga_send_fifo_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANE_W = 4,
   parameter int unsigned DEPTH  = 4
);
   import interfpga_pkg::*;

   localparam int unsigned LVL_W = clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [LANE_W-1:0] data_o;
   logic              ctrl_o;
   logic              busy;
   logic [LVL_W-1:0]  level;

   // Upstream producer / observer side.
   modport master (
      output in_data,
      output in_valid,
      output flush,
      input  in_ready,
      input  data_o,
      input  ctrl_o,
      input  busy,
      input  level
   );

   // Sender side.
   modport slave (
      input  in_data,
      input  in_valid,
      input  flush,
      output in_ready,
      output data_o,
      output ctrl_o,
      output busy,
      output level
   );

endinterface

// File: rtl/interfpga_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module interfpga_fifo
   import interfpga_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic             do_push;
   logic             do_pop;

   // A full FIFO never accepts, and a push coinciding with flush is dropped.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty;

   // Pointer update; flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= din;
   end

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level = wr_q - rd_q;
   assign dout  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/interfpga_send_fifo.sv
// Buffered inter-FPGA word sender: FIFO in front of a framing serialiser that
// shifts each word out LSB lane first, each beat held HOLD cycles, with ctrl_o
// framing the word and at least GAP low cycles between frames.
module interfpga_send_fifo
   import interfpga_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANE_W = 4,
   parameter int unsigned HOLD   = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned GAP    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   interfpga_send_fifo_if.slave bus
);

   localparam int unsigned BEATS  = beats(DATA_W, LANE_W);
   localparam int unsigned HOLD_W = cnt_w(HOLD);
   localparam int unsigned BEAT_W = cnt_w(BEATS);
   localparam int unsigned GAP_W  = cnt_w(GAP + 1);
   localparam int unsigned LVL_W  = clog2(DEPTH) + 1;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic [LVL_W-1:0]  fifo_level;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [LANE_W-1:0] data_q, data_d;
   logic              ctrl_q, ctrl_d;
   logic              start;

   // in_ready is a decode of registered pointers only.
   assign fifo_push = bus.in_valid & ~fifo_full;

   interfpga_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (bus.flush),
      .din     (bus.in_data),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Next-state and next-output decode for the framing FSM.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      beat_d   = beat_q;
      gap_d    = gap_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      fifo_pop = 1'b0;
      start    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ctrl_d = 1'b0;
            data_d = '0;
            start  = ~fifo_empty;
         end
         ST_SEND: begin
            if (hold_q == HOLD_W'(HOLD - 1)) begin
               hold_d = '0;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  beat_d  = '0;
                  ctrl_d  = 1'b0;
                  data_d  = '0;
                  gap_d   = GAP_W'(1);
                  state_d = ST_GAP;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  shreg_d = shreg_q >> LANE_W;
                  data_d  = shreg_d[LANE_W-1:0];
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_GAP: begin
            // Last gap cycle doubles as the idle check, keeping back-to-back spacing exact.
            if (gap_q == GAP_W'(GAP)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
               start   = ~fifo_empty;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ctrl_d  = 1'b0;
            data_d  = '0;
         end
      endcase

      // Frame launch: pop the head word and put beat 0 on the lane.
      if (start) begin
         fifo_pop = 1'b1;
         shreg_d  = fifo_dout;
         data_d   = fifo_dout[LANE_W-1:0];
         ctrl_d   = 1'b1;
         hold_d   = '0;
         beat_d   = '0;
         state_d  = ST_SEND;
      end
   end

   // State, counters, shift register and registered lane outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         ctrl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.in_ready = ~fifo_full;
   assign bus.data_o   = data_q;
   assign bus.ctrl_o   = ctrl_q;
   assign bus.level    = fifo_level;
   assign bus.busy     = ctrl_q | (fifo_level != '0);

endmodule

// File: tb/tb_interfpga_send_fifo.sv
// Bench for interfpga_send_fifo: default instance plus a 16-bit/HOLD=1/GAP=3 instance.
module tb_interfpga_send_fifo;

   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   interfpga_send_fifo_if #(.DATA_W(8),  .LANE_W(4), .DEPTH(4)) bus0 ();
   interfpga_send_fifo_if #(.DATA_W(16), .LANE_W(4), .DEPTH(4)) bus1 ();

   interfpga_send_fifo #(
      .DATA_W(8), .LANE_W(4), .HOLD(2), .DEPTH(4), .GAP(1)
   ) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   interfpga_send_fifo #(
      .DATA_W(16), .LANE_W(4), .HOLD(1), .DEPTH(4), .GAP(3)
   ) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.flush = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.flush = 1'b0;
      repeat (3) step();
      total++; if (bus0.ctrl_o !== 1'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0", bus0.ctrl_o); end
      total++; if (bus0.data_o !== 4'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus0.data_o); end
      total++; if (bus0.level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus0.level); end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus0.busy); end
      total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus0.in_ready); end
      total++; if (bus1.ctrl_o !== 1'b0 || bus1.in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_dut1 got ctrl=%b rdy=%b want ctrl=0 rdy=1", bus1.ctrl_o, bus1.in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) step();
      total++; if (bus0.ctrl_o !== 1'b0 || bus0.level !== 3'd0) begin
         bad++; $display("FAIL post_reset_idle got ctrl=%b level=%0d want 0/0", bus0.ctrl_o, bus0.level);
      end
   endtask

   task automatic test_single_frame();
      logic       ec [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] ed [7] = '{4'h0, 4'h5, 4'h5, 4'hA, 4'hA, 4'h0, 4'h0};
      logic [2:0] el [7] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      logic       eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      repeat (2) step();
      for (int k = 0; k < 7; k++) begin
         bus0.in_valid = (k == 0);
         bus0.in_data  = 8'hA5;
         step();
         total++;
         if (bus0.ctrl_o !== ec[k] || bus0.data_o !== ed[k] || bus0.level !== el[k] || bus0.busy !== eb[k]) begin
            bad++;
            $display("FAIL single_a5 k=%0d got ctrl=%b data=%h lvl=%0d busy=%b want ctrl=%b data=%h lvl=%0d busy=%b",
                     k, bus0.ctrl_o, bus0.data_o, bus0.level, bus0.busy, ec[k], ed[k], el[k], eb[k]);
         end
      end
      bus0.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] w  [3]  = '{8'h12, 8'h34, 8'h56};
      logic       ec [17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] ed [17] = '{4'h0, 4'h2, 4'h2, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h3, 4'h3, 4'h0,
                              4'h6, 4'h6, 4'h5, 4'h5, 4'h0, 4'h0};
      logic [2:0] el [17] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                              3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      int peak = 0;
      repeat (2) step();
      for (int k = 0; k < 17; k++) begin
         bus0.in_valid = (k < 3);
         bus0.in_data  = (k < 3) ? w[k] : 8'h00;
         step();
         if (int'(bus0.level) > peak) peak = int'(bus0.level);
         total++;
         if (bus0.ctrl_o !== ec[k] || bus0.data_o !== ed[k] || bus0.level !== el[k]) begin
            bad++;
            $display("FAIL b2b k=%0d got ctrl=%b data=%h lvl=%0d want ctrl=%b data=%h lvl=%0d",
                     k, bus0.ctrl_o, bus0.data_o, bus0.level, ec[k], ed[k], el[k]);
         end
      end
      total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak got=%0d want=2", peak); end
   endtask

   task automatic test_fill();
      logic [3:0] seen [$];
      int acc = 0;
      int n   = 0;
      repeat (2) step();
      bus0.in_valid = 1'b1;
      while (acc < 20 && bus0.in_ready === 1'b1) begin
         bus0.in_data = 8'hA0 + 8'(acc);
         acc++;
         step();
         if (bus0.ctrl_o === 1'b1) seen.push_back(bus0.data_o);
      end
      total++; if (acc != 5) begin bad++; $display("FAIL fill_accepted got=%0d want=5", acc); end
      total++; if (bus0.level !== 3'd4 || bus0.in_ready !== 1'b0) begin
         bad++; $display("FAIL fill_full got lvl=%0d rdy=%b want lvl=4 rdy=0", bus0.level, bus0.in_ready);
      end
      bus0.in_data = 8'hEE;
      step();
      if (bus0.ctrl_o === 1'b1) seen.push_back(bus0.data_o);
      total++; if (bus0.level !== 3'd4) begin bad++; $display("FAIL fill_no_overflow got lvl=%0d want=4", bus0.level); end
      bus0.in_valid = 1'b0;
      while (n < 60 && bus0.busy === 1'b1) begin
         n++;
         step();
         if (bus0.ctrl_o === 1'b1) seen.push_back(bus0.data_o);
      end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL fill_drain_timeout busy=%b want=0", bus0.busy); end
      total++; if (seen.size() != 20) begin bad++; $display("FAIL fill_beats got=%0d want=20", seen.size()); end
      for (int i = 0; i < 20 && i < seen.size(); i++) begin
         logic [3:0] exp_nib;
         exp_nib = ((i % 4) < 2) ? 4'(i / 4) : 4'hA;
         total++;
         if (seen[i] !== exp_nib) begin bad++; $display("FAIL fill_beat i=%0d got=%h want=%h", i, seen[i], exp_nib); end
      end
   endtask

   task automatic test_flush();
      logic [7:0] w  [3]  = '{8'h9C, 8'h22, 8'h33};
      logic       ec [15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] ed [15] = '{4'h0, 4'hC, 4'hC, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      logic [2:0] el [15] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      repeat (2) step();
      for (int k = 0; k < 15; k++) begin
         bus0.in_valid = (k <= 3);
         bus0.in_data  = (k < 3) ? w[k] : 8'h77;
         bus0.flush    = (k == 3);
         step();
         total++;
         if (bus0.ctrl_o !== ec[k] || bus0.data_o !== ed[k] || bus0.level !== el[k]) begin
            bad++;
            $display("FAIL flush k=%0d got ctrl=%b data=%h lvl=%0d want ctrl=%b data=%h lvl=%0d",
                     k, bus0.ctrl_o, bus0.data_o, bus0.level, ec[k], ed[k], el[k]);
         end
      end
      bus0.in_valid = 1'b0;
      bus0.flush    = 1'b0;
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus0.busy); end
   endtask

   task automatic test_wide();
      logic       ec [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] ed [14] = '{4'h0, 4'hF, 4'hE, 4'hE, 4'hB, 4'h0, 4'h0, 4'h0,
                              4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0};
      logic [2:0] el [14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                              3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      repeat (2) step();
      for (int k = 0; k < 14; k++) begin
         bus1.in_valid = (k < 2);
         bus1.in_data  = (k == 0) ? 16'hBEEF : 16'h1234;
         step();
         total++;
         if (bus1.ctrl_o !== ec[k] || bus1.data_o !== ed[k] || bus1.level !== el[k]) begin
            bad++;
            $display("FAIL wide k=%0d got ctrl=%b data=%h lvl=%0d want ctrl=%b data=%h lvl=%0d",
                     k, bus1.ctrl_o, bus1.data_o, bus1.level, ec[k], ed[k], el[k]);
         end
      end
      bus1.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic       ec [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] ed [7] = '{4'h0, 4'hC, 4'hC, 4'h3, 4'h3, 4'h0, 4'h0};
      repeat (2) step();
      for (int k = 0; k < 3; k++) begin
         bus0.in_valid = (k < 2);
         bus0.in_data  = (k == 0) ? 8'hA5 : 8'h5A;
         step();
      end
      bus0.in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (bus0.ctrl_o !== 1'b0 || bus0.data_o !== 4'h0 || bus0.level !== 3'd0 ||
          bus0.busy !== 1'b0 || bus0.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_reset got ctrl=%b data=%h lvl=%0d busy=%b rdy=%b want 0/0/0/0/1",
                  bus0.ctrl_o, bus0.data_o, bus0.level, bus0.busy, bus0.in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step();
      for (int k = 0; k < 7; k++) begin
         bus0.in_valid = (k == 0);
         bus0.in_data  = 8'h3C;
         step();
         total++;
         if (bus0.ctrl_o !== ec[k] || bus0.data_o !== ed[k]) begin
            bad++;
            $display("FAIL after_reset k=%0d got ctrl=%b data=%h want ctrl=%b data=%h",
                     k, bus0.ctrl_o, bus0.data_o, ec[k], ed[k]);
         end
      end
      bus0.in_valid = 1'b0;
   endtask

   // Reference: word i accepted at edge p starts at max(p+1, previous start + FRAME + GAP)
   // and shows nibble (t-start)/HOLD for FRAME cycles; level = accepted - started.
   task automatic test_random();
      int unsigned words [$];
      int          pe [$];
      int          se [$];
      int          last_s, lvl, pct, s;
      logic        exp_ctrl;
      logic [3:0]  exp_data;
      logic        v;
      logic [7:0]  w;
      last_s = -100;
      repeat (3) step();
      for (int e = 0; e < 420; e++) begin
         lvl      = 0;
         exp_ctrl = 1'b0;
         exp_data = 4'h0;
         for (int i = 0; i < words.size(); i++) begin
            if (pe[i] <= e - 1) lvl++;
            if (se[i] <= e - 1) lvl--;
            if (se[i] <= e - 1 && e - 1 < se[i] + 4) begin
               exp_ctrl = 1'b1;
               exp_data = 4'((words[i] >> (4 * ((e - 1 - se[i]) / 2))) & 32'hF);
            end
         end
         total++;
         if (bus0.ctrl_o !== exp_ctrl || bus0.data_o !== exp_data) begin
            bad++;
            $display("FAIL rand_lane e=%0d got ctrl=%b data=%h want ctrl=%b data=%h",
                     e, bus0.ctrl_o, bus0.data_o, exp_ctrl, exp_data);
         end
         total++;
         if (bus0.level !== 3'(lvl) || bus0.in_ready !== (lvl < 4) || bus0.busy !== (exp_ctrl | (lvl != 0))) begin
            bad++;
            $display("FAIL rand_fifo e=%0d got lvl=%0d rdy=%b busy=%b want lvl=%0d rdy=%b busy=%b",
                     e, bus0.level, bus0.in_ready, bus0.busy, lvl, (lvl < 4), (exp_ctrl | (lvl != 0)));
         end
         pct = (e < 120) ? 95 : (e < 240) ? 25 : (e < 360) ? 60 : 0;
         v   = ($urandom_range(99) < pct);
         w   = 8'($urandom);
         if (v && lvl < 4) begin
            s = (e + 1 > last_s + 5) ? e + 1 : last_s + 5;
            words.push_back(int'(w));
            pe.push_back(e);
            se.push_back(s);
            last_s = s;
         end
         bus0.in_valid = v;
         bus0.in_data  = w;
         step();
      end
      bus0.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_fill();
      test_flush();
      test_wide();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
